// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle of pipeline-control signals between the datapath
//                (master) and the hazard controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Pipeline state observed by the controller
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             if_id_md_use;
    logic             id_ex_mem_read;
    logic [REG_W-1:0] id_ex_rt;
    logic             md_start;
    logic             branch_taken;
    logic             mem_stall;

    // Pipeline controls produced by the controller
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_count;

    // Datapath side: drives pipeline status, consumes enables
    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rt, if_id_md_use,
               id_ex_mem_read, id_ex_rt, md_start, branch_taken, mem_stall,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
               id_ex_flush, pipe_hold, stall_count
    );

    // Controller side
    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rt, if_id_md_use,
               id_ex_mem_read, id_ex_rt, md_start, branch_taken, mem_stall,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush,
               id_ex_flush, pipe_hold, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller for the pipelined MIPS datapath.
//                Multi-cycle load-use stalls, mult/div busy tracking,
//                branch-taken flushes, data-memory freeze and a saturating
//                stalled-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int LOAD_LAT  = 1,
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    hazard_ctrl_if.slave    hz
);

    // Counter reload values, sized to their registers
    localparam logic [3:0] LCNT_INIT  = 4'(LOAD_LAT - 1);
    localparam logic [5:0] MDCNT_INIT = 6'(MD_CYCLES - 1);
    // A one-cycle load latency is fully covered by the detect cycle itself
    localparam bit         MULTI_LAT  = (LOAD_LAT > 1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       lcnt_q,  lcnt_d;
    logic [5:0]       mdcnt_q, mdcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_hit;
    logic md_busy;
    logic load_stall;
    logic md_stall;

    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_hold;

    // Load-use hazard: the load in EX writes a register that ID reads; $0 is exempt
    always_comb begin
        lu_hit = 1'b0;
        if (hz.id_ex_mem_read && (hz.id_ex_rt != '0)) begin
            lu_hit = (hz.id_ex_rt == hz.if_id_rs) ||
                     (hz.if_id_uses_rt && (hz.id_ex_rt == hz.if_id_rt));
        end
    end

    // Stall sources; an op entering EX this cycle already makes the unit busy
    always_comb begin
        md_busy    = hz.md_start || (mdcnt_q != 6'd0);
        md_stall   = md_busy && hz.if_id_md_use;
        load_stall = (state_q == LSTALL) || lu_hit;
    end

    // Pipeline controls in priority order: reset, freeze, branch, load, md, run
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_hold    = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (hz.mem_stall) begin
            // Whole pipe freezes; no bubble since nothing advances
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b1;
        end else if (hz.branch_taken) begin
            // Squash wrong-path work; overrides any stall on the squashed instruction
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_stall || md_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Next state for the load FSM, mult/div tracker and performance counter
    always_comb begin
        state_d     = state_q;
        lcnt_d      = lcnt_q;
        mdcnt_d     = mdcnt_q;
        stall_cnt_d = stall_cnt_q;

        if (!pc_write && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        // A memory wait state freezes all sequencing, including md_start sampling
        if (!hz.mem_stall) begin
            if (hz.md_start) begin
                mdcnt_d = MDCNT_INIT;
            end else if (mdcnt_q != 6'd0) begin
                mdcnt_d = mdcnt_q - 6'd1;
            end

            if (hz.branch_taken) begin
                state_d = RUN;
                lcnt_d  = 4'd0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (lu_hit && MULTI_LAT) begin
                            state_d = LSTALL;
                            lcnt_d  = LCNT_INIT;
                        end
                    end
                    LSTALL: begin
                        // ID/EX holds a bubble here, so lu_hit is not re-evaluated
                        lcnt_d = lcnt_q - 4'd1;
                        if (lcnt_q == 4'd1) begin
                            state_d = RUN;
                        end
                    end
                    default: begin
                        state_d = RUN;
                        lcnt_d  = 4'd0;
                    end
                endcase
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            lcnt_q      <= 4'd0;
            mdcnt_q     <= 6'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            mdcnt_q     <= mdcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.pipe_hold    = pipe_hold;
    assign hz.stall_count  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl. Instance A uses
//                LOAD_LAT=3, MD_CYCLES=4, CNT_W=4; instance B uses LOAD_LAT=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Control vectors: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, pipe_hold}
    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_STL = 6'b001000;
    localparam logic [5:0] C_FRZ = 6'b000001;
    localparam logic [5:0] C_BR  = 6'b110110;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   total;
    int   bad;

    hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  ifa ();
    hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ifb ();

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .MD_CYCLES(4), .CNT_W(4)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .hz    (ifa.slave)
    );

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .MD_CYCLES(4), .CNT_W(16)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .hz    (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs_a();
        return {ifa.pc_write, ifa.if_id_write, ifa.id_ex_bubble,
                ifa.if_id_flush, ifa.id_ex_flush, ifa.pipe_hold};
    endfunction

    function automatic logic [5:0] outs_b();
        return {ifb.pc_write, ifb.if_id_write, ifb.id_ex_bubble,
                ifb.if_id_flush, ifb.id_ex_flush, ifb.pipe_hold};
    endfunction

    task automatic idle_a();
        ifa.if_id_rs = '0; ifa.if_id_rt = '0; ifa.if_id_uses_rt = 1'b0;
        ifa.if_id_md_use = 1'b0; ifa.id_ex_mem_read = 1'b0; ifa.id_ex_rt = '0;
        ifa.md_start = 1'b0; ifa.branch_taken = 1'b0; ifa.mem_stall = 1'b0;
    endtask

    task automatic idle_b();
        ifb.if_id_rs = '0; ifb.if_id_rt = '0; ifb.if_id_uses_rt = 1'b0;
        ifb.if_id_md_use = 1'b0; ifb.id_ex_mem_read = 1'b0; ifb.id_ex_rt = '0;
        ifb.md_start = 1'b0; ifb.branch_taken = 1'b0; ifb.mem_stall = 1'b0;
    endtask

    // Advance to just after the next rising edge
    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge of the current cycle
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        idle_a();
        idle_b();

        // ---- Reset outputs, even with a branch pending ----
        ifa.branch_taken = 1'b1;
        smp(); chk("reset_ctl_a", 32'(outs_a()), 32'(C_STL));
        chk("reset_ctl_b", 32'(outs_b()), 32'(C_STL));
        nx();
        idle_a();
        nx();
        reset_a = 1'b0;
        reset_b = 1'b0;
        smp(); chk("post_reset_run_a", 32'(outs_a()), 32'(C_RUN));
        chk("post_reset_cnt_a", 32'(ifa.stall_count), 0);
        chk("post_reset_run_b", 32'(outs_b()), 32'(C_RUN));
        nx();

        // ---- Load-use, LOAD_LAT=3: lw r8 then add r9,r8,r1 ----
        ifa.id_ex_mem_read = 1'b1; ifa.id_ex_rt = 5'd8; ifa.if_id_rs = 5'd8; ifa.if_id_rt = 5'd1;
        smp(); chk("lu_stall1", 32'(outs_a()), 32'(C_STL));
        nx();
        ifa.id_ex_mem_read = 1'b0; ifa.id_ex_rt = 5'd0;   // bubble now in ID/EX
        smp(); chk("lu_stall2", 32'(outs_a()), 32'(C_STL));
        nx();
        smp(); chk("lu_stall3", 32'(outs_a()), 32'(C_STL));
        nx();
        smp(); chk("lu_release", 32'(outs_a()), 32'(C_RUN));
        chk("lu_count", 32'(ifa.stall_count), 3);
        nx();

        // ---- $0 and uses_rt exemptions ----
        idle_a();
        ifa.id_ex_mem_read = 1'b1; ifa.id_ex_rt = 5'd0; ifa.if_id_rs = 5'd0;
        smp(); chk("zero_reg_exempt", 32'(outs_a()), 32'(C_RUN));
        nx();
        ifa.id_ex_rt = 5'd5; ifa.if_id_rt = 5'd5; ifa.if_id_rs = 5'd3; ifa.if_id_uses_rt = 1'b0;
        smp(); chk("rt_unused_exempt", 32'(outs_a()), 32'(C_RUN));
        nx();
        ifa.if_id_uses_rt = 1'b1;
        smp(); chk("rt_used_hit", 32'(outs_a()), 32'(C_STL));
        nx();
        ifa.id_ex_mem_read = 1'b0; ifa.id_ex_rt = 5'd0;
        smp(); chk("rt_stall2", 32'(outs_a()), 32'(C_STL));
        nx(); nx();
        idle_a();
        smp(); chk("rt_release", 32'(outs_a()), 32'(C_RUN));
        nx();

        // ---- Mult/div, MD_CYCLES=4: md_start at c0, mflo in ID from c1 ----
        ifa.md_start = 1'b1;
        smp(); chk("md_start_no_use", 32'(outs_a()), 32'(C_RUN));
        nx();
        ifa.md_start = 1'b0; ifa.if_id_md_use = 1'b1;
        smp(); chk("md_stall_c1", 32'(outs_a()), 32'(C_STL));
        nx();
        smp(); chk("md_stall_c2", 32'(outs_a()), 32'(C_STL));
        nx();
        smp(); chk("md_stall_c3", 32'(outs_a()), 32'(C_STL));
        nx();
        smp(); chk("md_release_c4", 32'(outs_a()), 32'(C_RUN));
        chk("md_count", 32'(ifa.stall_count), 9);
        nx();

        // ---- Back-to-back md_start: newest op reloads the tracker ----
        idle_a();
        ifa.md_start = 1'b1;
        nx();
        nx();
        ifa.md_start = 1'b0; ifa.if_id_md_use = 1'b1;
        smp(); chk("md_reload_c2", 32'(outs_a()), 32'(C_STL));
        nx(); nx();
        smp(); chk("md_reload_c4", 32'(outs_a()), 32'(C_STL));
        nx();
        smp(); chk("md_reload_c5", 32'(outs_a()), 32'(C_RUN));
        chk("md_reload_count", 32'(ifa.stall_count), 12);
        nx();

        // ---- Branch taken in the 2nd load stall cycle ----
        idle_a();
        ifa.id_ex_mem_read = 1'b1; ifa.id_ex_rt = 5'd8; ifa.if_id_rs = 5'd8;
        smp(); chk("br_lu_stall1", 32'(outs_a()), 32'(C_STL));
        nx();
        ifa.id_ex_mem_read = 1'b0; ifa.id_ex_rt = 5'd0; ifa.branch_taken = 1'b1;
        smp(); chk("br_flush", 32'(outs_a()), 32'(C_BR));
        nx();
        idle_a();
        smp(); chk("br_after_run", 32'(outs_a()), 32'(C_RUN));
        chk("br_count", 32'(ifa.stall_count), 13);
        nx();

        // ---- Reset in the middle of a load stall ----
        ifa.id_ex_mem_read = 1'b1; ifa.id_ex_rt = 5'd8; ifa.if_id_rs = 5'd8;
        nx();
        ifa.id_ex_mem_read = 1'b0; ifa.id_ex_rt = 5'd0;
        reset_a = 1'b1;
        smp(); chk("rst_mid_ctl", 32'(outs_a()), 32'(C_STL));
        nx();
        reset_a = 1'b0;
        smp(); chk("rst_mid_run", 32'(outs_a()), 32'(C_RUN));
        chk("rst_mid_count", 32'(ifa.stall_count), 0);
        nx();

        // ---- Saturation with CNT_W=4: 20 frozen cycles ----
        idle_a();
        ifa.mem_stall = 1'b1;
        smp(); chk("sat_freeze_ctl", 32'(outs_a()), 32'(C_FRZ));
        for (int i = 0; i < 20; i++) nx();
        ifa.mem_stall = 1'b0;
        smp(); chk("sat_count", 32'(ifa.stall_count), 15);
        chk("sat_after_run", 32'(outs_a()), 32'(C_RUN));
        nx();

        // ---- Instance B, LOAD_LAT=2: 2-cycle freeze inside the load stall ----
        ifb.id_ex_mem_read = 1'b1; ifb.id_ex_rt = 5'd8; ifb.if_id_rs = 5'd8;
        smp(); chk("frz_lu_stall1", 32'(outs_b()), 32'(C_STL));
        nx();
        ifb.id_ex_mem_read = 1'b0; ifb.id_ex_rt = 5'd0;
        ifb.mem_stall = 1'b1; ifb.md_start = 1'b1;      // md_start must be ignored
        smp(); chk("frz_hold1", 32'(outs_b()), 32'(C_FRZ));
        nx();
        ifb.md_start = 1'b0;
        smp(); chk("frz_hold2", 32'(outs_b()), 32'(C_FRZ));
        nx();
        ifb.mem_stall = 1'b0; ifb.if_id_md_use = 1'b1;
        smp(); chk("frz_lu_resume", 32'(outs_b()), 32'(C_STL));
        nx();
        smp(); chk("frz_release", 32'(outs_b()), 32'(C_RUN));
        chk("frz_count", 32'(ifb.stall_count), 4);
        nx();
        idle_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
